// File: rtl/s_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// s_mem_arbiter_if
//
// Purpose: bundles the requester-side and S-memory-side signals of the
// S memory arbiter so the arbiter and its environment connect through a
// single port.
//
// Signals:
//   rq_start      [2:0]  per-requester request (bit0 init, bit1 shuffle,
//                        bit2 decrypt), held until that requester's finish
//   rq_address    [23:0] requester k address at [8k+7:8k]
//   rq_data_out   [23:0] requester k write data at [8k+7:8k]
//   rq_readWrite  [2:0]  per-requester operation, 1 = write, 0 = read
//   rq_finish     [2:0]  one-cycle completion pulse to the owning requester
//   rq_data_in    [7:0]  read data returned to the requester
//   mem_start            one-cycle start pulse to the S memory interface
//   mem_address   [7:0]  granted address
//   mem_data_out  [7:0]  granted write data
//   mem_readWrite        granted operation
//   mem_finish           memory completion pulse
//   mem_data_in   [7:0]  memory read data, valid with mem_finish
//   grant_valid          an access is owned
//   grant_id      [1:0]  current owner
//
// Modports:
//   master - the arbiter itself (drives the memory bus and the grants)
//   slave  - the environment (requesters and the S memory interface)
// -----------------------------------------------------------------------------
interface s_mem_arbiter_if;
  logic [2:0]  rq_start;
  logic [23:0] rq_address;
  logic [23:0] rq_data_out;
  logic [2:0]  rq_readWrite;
  logic [2:0]  rq_finish;
  logic [7:0]  rq_data_in;
  logic        mem_start;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data_out;
  logic        mem_readWrite;
  logic        mem_finish;
  logic [7:0]  mem_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;

  modport master (
    input  rq_start, rq_address, rq_data_out, rq_readWrite,
    input  mem_finish, mem_data_in,
    output rq_finish, rq_data_in,
    output mem_start, mem_address, mem_data_out, mem_readWrite,
    output grant_valid, grant_id
  );

  modport slave (
    output rq_start, rq_address, rq_data_out, rq_readWrite,
    output mem_finish, mem_data_in,
    input  rq_finish, rq_data_in,
    input  mem_start, mem_address, mem_data_out, mem_readWrite,
    input  grant_valid, grant_id
  );
endinterface

// File: rtl/s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// s_mem_arbiter
//
// Purpose: shares one S memory interface between three requesters (init,
// shuffle, decrypt). One access is in flight at a time; the grant is locked
// from arbitration until the requester's finish pulse.
//
// Ports:
//   clk    - single clock, all state updates on its rising edge
//   reset  - asynchronous, active-high reset
//   bus    - s_mem_arbiter_if.master: requester handshakes, memory bus,
//            grant status
//
// Configuration:
//   S_ARB_ROUND_ROBIN_EN - when defined, round-robin arbitration starting
//                          after the last granted requester; when undefined,
//                          fixed priority decrypt (2) > shuffle (1) > init (0).
//
// Timing: request seen in IDLE at cycle N -> mem_start at N+1;
//         mem_finish at cycle M -> rq_finish at M+1.
// -----------------------------------------------------------------------------
module s_mem_arbiter (
  input  logic             clk,
  input  logic             reset,
  s_mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic [7:0]  mem_address_q, mem_address_d;
  logic [7:0]  mem_data_out_q, mem_data_out_d;
  logic        mem_read_write_q, mem_read_write_d;
  logic [7:0]  rq_data_in_q, rq_data_in_d;
  logic        grant_valid_q, grant_valid_d;
  logic [1:0]  grant_id_q, grant_id_d;

  logic        any_req;
  logic [1:0]  winner;
  logic [7:0]  sel_address;
  logic [7:0]  sel_data;
  logic        sel_read_write;
  logic [2:0]  rq_finish;

  assign any_req = |bus.rq_start;

`ifdef S_ARB_ROUND_ROBIN_EN
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  rr_first;
  logic [1:0]  rr_cand;
  logic        rr_found;

  // Search the three requesters starting one past the last owner, wrapping
  // modulo 3; the first active request wins.
  always_comb begin
    winner   = 2'd0;
    rr_found = 1'b0;
    rr_first = (last_grant_q >= 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    rr_cand  = rr_first;
    for (int i = 0; i < 3; i++) begin
      if (!rr_found && bus.rq_start[rr_cand]) begin
        winner   = rr_cand;
        rr_found = 1'b1;
      end
      rr_cand = (rr_cand == 2'd2) ? 2'd0 : rr_cand + 2'd1;
    end
  end
`else
  // Fixed priority: decrypt beats shuffle beats init.
  always_comb begin
    winner = 2'd0;
    if (bus.rq_start[2]) begin
      winner = 2'd2;
    end else if (bus.rq_start[1]) begin
      winner = 2'd1;
    end
  end
`endif

  // Pick the winner's byte lanes out of the packed request buses.
  always_comb begin
    sel_address    = bus.rq_address[7:0];
    sel_data       = bus.rq_data_out[7:0];
    sel_read_write = bus.rq_readWrite[0];
    case (winner)
      2'd1: begin
        sel_address    = bus.rq_address[15:8];
        sel_data       = bus.rq_data_out[15:8];
        sel_read_write = bus.rq_readWrite[1];
      end
      2'd2: begin
        sel_address    = bus.rq_address[23:16];
        sel_data       = bus.rq_data_out[23:16];
        sel_read_write = bus.rq_readWrite[2];
      end
      default: begin
        sel_address    = bus.rq_address[7:0];
        sel_data       = bus.rq_data_out[7:0];
        sel_read_write = bus.rq_readWrite[0];
      end
    endcase
  end

  // Next-state logic. Arbitration only happens in IDLE, so the grant and the
  // latched memory request stay fixed through ISSUE, WAIT and DONE even if
  // rq_start changes. mem_finish is only looked at in WAIT.
  always_comb begin
    state_d          = state_q;
    mem_address_d    = mem_address_q;
    mem_data_out_d   = mem_data_out_q;
    mem_read_write_d = mem_read_write_q;
    rq_data_in_d     = rq_data_in_q;
    grant_valid_d    = grant_valid_q;
    grant_id_d       = grant_id_q;
`ifdef S_ARB_ROUND_ROBIN_EN
    last_grant_d     = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_address_d    = sel_address;
          mem_data_out_d   = sel_data;
          mem_read_write_d = sel_read_write;
          grant_valid_d    = 1'b1;
          grant_id_d       = winner;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_finish) begin
          rq_data_in_d = bus.mem_data_in;
          state_d      = DONE;
        end
      end
      DONE: begin
        grant_valid_d = 1'b0;
`ifdef S_ARB_ROUND_ROBIN_EN
        last_grant_d  = grant_id_q;
`endif
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset returns to IDLE immediately, even mid-access; the aborted access
  // never completes, so a later stray mem_finish is simply ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      mem_address_q    <= 8'h00;
      mem_data_out_q   <= 8'h00;
      mem_read_write_q <= 1'b0;
      rq_data_in_q     <= 8'h00;
      grant_valid_q    <= 1'b0;
      grant_id_q       <= 2'd0;
    end else begin
      state_q          <= state_d;
      mem_address_q    <= mem_address_d;
      mem_data_out_q   <= mem_data_out_d;
      mem_read_write_q <= mem_read_write_d;
      rq_data_in_q     <= rq_data_in_d;
      grant_valid_q    <= grant_valid_d;
      grant_id_q       <= grant_id_d;
    end
  end

`ifdef S_ARB_ROUND_ROBIN_EN
  // Resetting the pointer to 2 makes requester 0 the first one searched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 2'd2;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // One-hot completion pulse to the owner, decoded from the registered state.
  always_comb begin
    rq_finish = 3'b000;
    if (state_q == DONE) begin
      case (grant_id_q)
        2'd1:    rq_finish = 3'b010;
        2'd2:    rq_finish = 3'b100;
        default: rq_finish = 3'b001;
      endcase
    end
  end

  assign bus.mem_start     = (state_q == ISSUE);
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_data_out  = mem_data_out_q;
  assign bus.mem_readWrite = mem_read_write_q;
  assign bus.rq_finish     = rq_finish;
  assign bus.rq_data_in    = rq_data_in_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_id      = grant_id_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_mem_arbiter
//
// Purpose: directed, self-checking bench for s_mem_arbiter. Expected grants
// are pushed to a scoreboard queue when requests are driven and popped when
// the arbiter issues mem_start; a small inline memory responder returns data
// after a chosen latency. Define S_ARB_ROUND_ROBIN_EN to exercise the
// round-robin build.
// -----------------------------------------------------------------------------
module tb_s_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  s_mem_arbiter_if bus ();

  s_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rw;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] start, input logic [23:0] addr,
                               input logic [23:0] data, input logic [2:0] rw);
    bus.rq_start     = start;
    bus.rq_address   = addr;
    bus.rq_data_out  = data;
    bus.rq_readWrite = rw;
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic rw);
    exp_t e;
    e.id    = id;
    e.addr  = addr;
    e.wdata = wdata;
    e.rw    = rw;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset           = 1'b1;
    bus.rq_start    = 3'b000;
    bus.mem_finish  = 1'b0;
    bus.mem_data_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_start"},     bus.mem_start,     0);
    checkOutput({tag, "_mem_address"},   bus.mem_address,   0);
    checkOutput({tag, "_mem_data_out"},  bus.mem_data_out,  0);
    checkOutput({tag, "_mem_readWrite"}, bus.mem_readWrite, 0);
    checkOutput({tag, "_rq_finish"},     bus.rq_finish,     0);
    checkOutput({tag, "_rq_data_in"},    bus.rq_data_in,    0);
    checkOutput({tag, "_grant_valid"},   bus.grant_valid,   0);
    checkOutput({tag, "_grant_id"},      bus.grant_id,      0);
  endtask

  // Serve one access: wait for mem_start, compare against the scoreboard,
  // optionally raise extra requests in the first WAIT cycle, return rdata
  // after 'latency' cycles, then check the finish pulse and release.
  task automatic serveOne(input int latency, input logic [7:0] rdata,
                          input logic [2:0] raise_mask, input logic [2:0] drop_mask);
    exp_t e;
    int   n;
    bit   seen;
    bit   have;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_start === 1'b1) seen = 1'b1;
    end
    checkOutput("mem_start_seen", seen, 1);
    if (!seen) return;
    have = (expQ.size() != 0);
    checkOutput("scoreboard_entry", have, 1);
    if (!have) return;
    e = expQ.pop_front();
    checkOutput("start_latency",  n,                 1);
    checkOutput("grant_valid",    bus.grant_valid,   1);
    checkOutput("grant_id",       bus.grant_id,      e.id);
    checkOutput("mem_address",    bus.mem_address,   e.addr);
    checkOutput("mem_data_out",   bus.mem_data_out,  e.wdata);
    checkOutput("mem_readWrite",  bus.mem_readWrite, e.rw);
    for (int c = 1; c <= latency; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("mem_start_single", bus.mem_start, 0);
        bus.rq_start = bus.rq_start | raise_mask;
      end
      checkOutput("grant_locked",   bus.grant_id,    e.id);
      checkOutput("address_stable", bus.mem_address, e.addr);
      checkOutput("finish_early",   bus.rq_finish,   0);
      if (c == latency) begin
        bus.mem_finish  = 1'b1;
        bus.mem_data_in = rdata;
      end
    end
    @(negedge clk);
    bus.mem_finish  = 1'b0;
    bus.mem_data_in = 8'h00;
    checkOutput("rq_finish",  bus.rq_finish,  3'b001 << e.id);
    checkOutput("rq_data_in", bus.rq_data_in, rdata);
    bus.rq_start = bus.rq_start & ~drop_mask;
    @(negedge clk);
    checkOutput("finish_single",  bus.rq_finish,   0);
    checkOutput("grant_released", bus.grant_valid, 0);
    checkOutput("rq_data_held",   bus.rq_data_in,  rdata);
  endtask

  initial begin
    int  n;
    bit  seen;

    reset            = 1'b1;
    bus.rq_start     = 3'b000;
    bus.rq_address   = 24'h0;
    bus.rq_data_out  = 24'h0;
    bus.rq_readWrite = 3'b000;
    bus.mem_finish   = 1'b0;
    bus.mem_data_in  = 8'h00;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // No requests: stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_mem_start",   bus.mem_start,   0);
      checkOutput("idle_grant_valid", bus.grant_valid, 0);
    end

    // Single read by init.
    $display("[TB] single read");
    applyStimulus(3'b001, 24'h0000_10, 24'h0, 3'b000);
    pushExp(2'd0, 8'h10, 8'h00, 1'b0);
    serveOne(2, 8'hA5, 3'b000, 3'b001);

    // Single write by shuffle, memory answers in the first WAIT cycle.
    $display("[TB] single write");
    applyStimulus(3'b010, 24'h00FF00, 24'h003C00, 3'b010);
    pushExp(2'd1, 8'hFF, 8'h3C, 1'b1);
    serveOne(1, 8'h5A, 3'b000, 3'b010);

`ifndef S_ARB_ROUND_ROBIN_EN
    // All three at once: fixed priority 2, 1, 0.
    $display("[TB] fixed priority");
    applyStimulus(3'b111, 24'h221101, 24'hC2C1C0, 3'b101);
    pushExp(2'd2, 8'h22, 8'hC2, 1'b1);
    pushExp(2'd1, 8'h11, 8'hC1, 1'b0);
    pushExp(2'd0, 8'h01, 8'hC0, 1'b1);
    serveOne(2, 8'h02, 3'b000, 3'b100);
    serveOne(3, 8'h01, 3'b000, 3'b010);
    serveOne(1, 8'h00, 3'b000, 3'b001);
`else
    // All three held: round robin 0, 1, 2, 0, 1, 2 from a fresh pointer.
    $display("[TB] round robin");
    doReset();
    applyStimulus(3'b111, 24'h221101, 24'hC2C1C0, 3'b101);
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0:       pushExp(2'd0, 8'h01, 8'hC0, 1'b1);
        1:       pushExp(2'd1, 8'h11, 8'hC1, 1'b0);
        default: pushExp(2'd2, 8'h22, 8'hC2, 1'b1);
      endcase
      serveOne(1 + (k % 2), 8'(8'h40 + k), 3'b000, (k == 5) ? 3'b111 : 3'b000);
    end
`endif

    // Decrypt request arriving mid-access does not steal the grant.
    $display("[TB] request change during access");
    doReset();
    applyStimulus(3'b001, 24'h330007, 24'h000000, 3'b000);
    pushExp(2'd0, 8'h07, 8'h00, 1'b0);
    pushExp(2'd2, 8'h33, 8'h00, 1'b0);
    serveOne(3, 8'h77, 3'b100, 3'b001);
    serveOne(2, 8'h88, 3'b000, 3'b100);

    // Reset in WAIT, then a stray mem_finish.
    $display("[TB] reset mid-access");
    applyStimulus(3'b010, 24'h004400, 24'h009900, 3'b010);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_start === 1'b1) seen = 1'b1;
    end
    checkOutput("abort_mem_start_seen", seen, 1);
    @(negedge clk);
    checkOutput("abort_grant_valid", bus.grant_valid, 1);
    checkOutput("abort_mem_address", bus.mem_address, 8'h44);
    reset        = 1'b1;
    bus.rq_start = 3'b000;
    #1;
    checkAllZero("abort");
    @(negedge clk);
    reset          = 1'b0;
    bus.mem_finish  = 1'b1;
    bus.mem_data_in = 8'hEE;
    @(negedge clk);
    bus.mem_finish  = 1'b0;
    bus.mem_data_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stray_rq_finish",  bus.rq_finish,   0);
      checkOutput("stray_mem_start",  bus.mem_start,   0);
      checkOutput("stray_rq_data_in", bus.rq_data_in,  0);
      @(negedge clk);
    end

    // Request pending across reset is served right after release.
    $display("[TB] request pending through reset");
    reset = 1'b1;
    applyStimulus(3'b001, 24'h00005C, 24'h000000, 3'b000);
    pushExp(2'd0, 8'h5C, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    serveOne(2, 8'h3D, 3'b000, 3'b001);

    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the directed sequence somehow stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/s_mem_arbiter.md
S_MEM_ARBITER -- requirements
Module: s_mem_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port rq_start, input, 3 bits: per-requester access request (bit0 init, bit1 shuffle, bit2 decrypt), held high until that requester's finish pulse.
REQ-004 The block SHALL have port rq_address, input, 24 bits: requester k address at bits [8k+7:8k].
REQ-005 The block SHALL have port rq_data_out, input, 24 bits: requester k write data at bits [8k+7:8k].
REQ-006 The block SHALL have port rq_readWrite, input, 3 bits: per-requester operation select, 1 = write, 0 = read.
REQ-007 The block SHALL have port rq_finish, output, 3 bits: one-cycle completion pulse to the owning requester.
REQ-008 The block SHALL have port rq_data_in, output, 8 bits: read data, valid while rq_finish is high and held until the next completion.
REQ-009 The block SHALL have port mem_start, output, 1 bit: one-cycle start pulse to the S memory interface.
REQ-010 The block SHALL have ports mem_address (output, 8 bits), mem_data_out (output, 8 bits) and mem_readWrite (output, 1 bit): the granted request, stable from mem_start until mem_finish.
REQ-011 The block SHALL have port mem_finish, input, 1 bit: memory-interface completion pulse.
REQ-012 The block SHALL have port mem_data_in, input, 8 bits: read data, valid in the mem_finish cycle.
REQ-013 The block SHALL have ports grant_valid (output, 1 bit) and grant_id (output, 2 bits): the current owner, for debug and status.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, all registered.
REQ-015 In IDLE with any rq_start bit high, the block SHALL select the winner, latch its address, data and readWrite into the mem_* registers, set grant_valid=1 and grant_id=winner, and go to ISSUE.
REQ-016 In ISSUE, mem_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-017 In WAIT, the FSM SHALL stay until mem_finish=1, then latch mem_data_in into rq_data_in and go to DONE.
REQ-018 In DONE, rq_finish[grant_id] SHALL be 1 for one cycle with all other bits 0, grant_valid SHALL clear, and the FSM SHALL go to IDLE.
REQ-019 Latency: request seen in IDLE at cycle N gives mem_start at N+1; mem_finish at cycle M gives rq_finish at M+1.
REQ-020 The block SHALL NOT re-arbitrate while the FSM is in ISSUE, WAIT or DONE; the grant is locked for the whole access.
REQ-021 The block SHALL ignore mem_finish outside WAIT.
REQ-022 mem_finish arriving in the first WAIT cycle SHALL be accepted; this is a minimum round trip of 4 cycles.
REQ-023 A requester dropping rq_start mid-access SHALL NOT abort the access; completion still pulses rq_finish.
REQ-024 Default arbitration SHALL be fixed priority: decrypt (2) > shuffle (1) > init (0).
REQ-025 With no requests, the FSM SHALL remain in IDLE and mem_start SHALL be 0.

Reset
REQ-026 When reset is asserted at any time, including mid-access, the FSM SHALL go to IDLE immediately.
REQ-027 On reset, the following outputs SHALL be 0: mem_start, mem_address, mem_data_out, mem_readWrite, rq_finish, rq_data_in, grant_valid and grant_id.
REQ-028 On reset, the round-robin pointer SHALL be set to point at requester 0 as highest priority.
REQ-029 After a reset, a pending rq_start SHALL be arbitrated in the first cycle following deassertion.

Configuration
REQ-030 When S_ARB_ROUND_ROBIN_EN is defined, arbitration SHALL be round-robin.
REQ-031 In round-robin mode, the search SHALL start at (last_grant+1) mod 3, and last_grant SHALL update on each DONE.
REQ-032 When S_ARB_ROUND_ROBIN_EN is undefined, arbitration SHALL be fixed priority per REQ-024 and the pointer logic SHALL be absent.

Verification
REQ-033 The bench SHALL cover a single read: rq_start=001, address 0x10, memory returns 0xA5 two cycles after mem_start -> mem_address=0x10, mem_readWrite=0, rq_finish=001 with rq_data_in=0xA5.
REQ-034 The bench SHALL cover a single write: requester 1, address 0xFF, data 0x3C, readWrite=1 -> mem_data_out=0x3C, one mem_start pulse, rq_finish=010.
REQ-035 The bench SHALL cover simultaneous requests in fixed mode: rq_start=111 held -> grants in order 2, 1, 0, one access in flight at a time.
REQ-036 The bench SHALL cover simultaneous requests with S_ARB_ROUND_ROBIN_EN defined: rq_start=111 held for 6 accesses -> grant_id sequence 0, 1, 2, 0, 1, 2.
REQ-037 The bench SHALL cover reset asserted in WAIT: state IDLE with all outputs 0; a later stray mem_finish gives no rq_finish pulse.
REQ-038 The bench SHALL cover a request change during an access: requester 0 in WAIT while rq_start[2] rises -> grant_id stays 0 until DONE, then requester 2 is served next.
